// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the hxd32 fetch unit.
// Produces the fetch address with a valid/ready handshake, computes redirect
// targets (JALR, ALU, trap entry, MRET) and parks in HALT on a misaligned
// jump target until a trap redirect recovers it.
module pc_gen #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = '0,
  parameter int               IALIGN    = 16
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            pc_wr_en_i,
  input  logic [2:0]      pc_wr_sel_i,
  input  logic [1:0]      pc_inc_sel_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            if_ready_i,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_data_o,
  output logic [XLEN-1:0] pc_prev_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_addr_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [2:0] SEL_NEXT = 3'd0;
  localparam logic [2:0] SEL_JALR = 3'd1;
  localparam logic [2:0] SEL_ALU  = 3'd2;
  localparam logic [2:0] SEL_TRAP = 3'd3;
  localparam logic [2:0] SEL_MRET = 3'd4;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] prev_q, prev_d;
  logic [XLEN-1:0] addr_q, addr_d;

  logic [XLEN-1:0] inc_base;
  logic [XLEN-1:0] inc_step;
  logic [XLEN-1:0] mret_mask;
  logic [XLEN-1:0] target;
  logic            is_jump;
  logic            misaligned;
  logic            accept_run;

  // Target address for the current select; compressed-off configs force +4 steps.
  always_comb begin
    inc_base   = pc_inc_sel_i[1] ? prev_q : pc_q;
    inc_step   = (pc_inc_sel_i[0] && (IALIGN == 16)) ? XLEN'(2) : XLEN'(4);
    mret_mask  = (IALIGN == 32) ? ~XLEN'(3) : ~XLEN'(1);
    target     = RESET_VEC;
    case (pc_wr_sel_i)
      SEL_NEXT: target = inc_base + inc_step;
      SEL_JALR: target = alu_data_i & ~XLEN'(1);
      SEL_ALU:  target = alu_data_i;
      SEL_TRAP: target = trap_vec_i & ~XLEN'(3);
      SEL_MRET: target = epc_i & mret_mask;
      default:  target = RESET_VEC;
    endcase
    is_jump    = (pc_wr_sel_i == SEL_JALR) || (pc_wr_sel_i == SEL_ALU);
    misaligned = is_jump && ((IALIGN == 32) ? target[1] : target[0]);
    accept_run = pc_wr_en_i && ((pc_wr_sel_i != SEL_NEXT) || if_ready_i);
  end

  // Next-state, next-PC and state-decoded outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    prev_d     = prev_q;
    addr_d     = addr_q;
    pc_valid_o = 1'b0;
    misalign_o = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        pc_valid_o = 1'b1;
        if (accept_run) begin
          if (misaligned) begin
            addr_d  = target;
            state_d = HALT;
          end else begin
            pc_d   = target;
            prev_d = pc_q;
          end
        end
      end
      HALT: begin
        misalign_o = 1'b1;
        if (pc_wr_en_i && (pc_wr_sel_i == SEL_TRAP)) begin
          pc_d    = target;
          prev_d  = pc_q;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State and PC registers; reset discards any pending fault.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      prev_q  <= RESET_VEC;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      prev_q  <= prev_d;
      addr_q  <= addr_d;
    end
  end

  assign pc_data_o       = pc_q;
  assign pc_prev_o       = prev_q;
  assign misalign_addr_o = addr_q;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the hxd32 fetch unit. It supports a configurable reset vector, 16/32-bit instruction alignment, and trap-entry and MRET redirects. It adds a valid/ready fetch handshake and misaligned-target detection with a halt state. It sits between the control unit (write enable/selects), the ALU (computed targets), the CSR block (trap vector, EPC) and the instruction-fetch port.

Parameters:
XLEN, 32, datapath/address width
RESET_VEC, 32'h0000_0000, PC value loaded on reset (XLEN bits)
IALIGN, 16, instruction alignment in bits; legal values 16 (compressed enabled) or 32

Ports:
clk_i  input  1  clock
rst_n_i  input  1  asynchronous active-low reset
pc_wr_en_i  input  1  PC write request
pc_wr_sel_i  input  3  0 NEXT, 1 JALR, 2 ALU, 3 TRAP, 4 MRET, 5-7 reserved
pc_inc_sel_i  input  2  0 INC4 (pc+4), 1 INC2 (pc+2), 2 INC4P (pc_prev+4), 3 INC2P (pc_prev+2)
alu_data_i  input  XLEN  ALU-computed target
trap_vec_i  input  XLEN  trap vector base from CSR block
epc_i  input  XLEN  exception return address from CSR block
if_ready_i  input  1  fetch port accepts current PC
pc_valid_o  output  1  pc_data_o is a valid fetch address
pc_data_o  output  XLEN  current PC
pc_prev_o  output  XLEN  PC before the last accepted write
misalign_o  output  1  misaligned-target fault pending
misalign_addr_o  output  XLEN  offending target address

Behaviour:
- Reset (async assert, sync-to-clock deassert handled upstream):
  - pc = pc_prev = RESET_VEC; state BOOT.
  - pc_valid_o = 0, misalign_o = 0, misalign_addr_o = 0.
- States:
  - BOOT: valid = 0; unconditionally moves to RUN next cycle; all writes ignored.
  - RUN: valid = 1.
  - HALT: valid = 0, misalign_o = 1.
- Write acceptance in RUN:
  - NEXT is accepted only when pc_wr_en_i && if_ready_i (no advance without handshake).
  - All other selects are flush redirects: accepted when pc_wr_en_i, regardless of if_ready_i.
- Target computation:
  - NEXT: per pc_inc_sel_i.
  - JALR: {alu[XLEN-1:1], 0}.
  - ALU: alu raw.
  - TRAP: {trap_vec[XLEN-1:2], 00}.
  - MRET: epc with bit0 cleared; bits[1:0] cleared when IALIGN=32.
  - Reserved selects (5-7): RESET_VEC.
- Arithmetic: all sums are modulo 2^XLEN (0xFFFF_FFFC + 4 = 0).
- IALIGN=32: INC2 and INC2P behave as INC4 and INC4P.
- Accepted write: pc <= target and pc_prev <= old pc, same edge. Single-cycle latency: the new pc is visible the cycle after the write edge.
- Misalign check (JALR and ALU only, IALIGN=32):
  - Triggers when target[1] = 1.
  - pc and pc_prev are NOT updated.
  - misalign_addr_o <= target; state -> HALT on the same edge.
  - For IALIGN=16, JALR never faults (bit0 already cleared); ALU faults when target[0] = 1.
- HALT:
  - Only a TRAP write is accepted. It loads the trap target, clears misalign_o, and returns to RUN.
  - All other writes are ignored; pc holds.
- pc_valid_o is registered state-derived; it does not depend combinationally on any input.
- No write while pc_wr_en_i = 0: pc and pc_prev hold in all states.
- Reset mid-operation (any state): immediate return to reset values; any pending fault is discarded.

Test Plan:
- Reset RESET_VEC=0x100, release: cycle 0 valid=0, pc=0x100; cycle 1 valid=1. NEXT/INC4 with ready=1 for 3 cycles -> pc 0x104, 0x108, 0x10C; pc_prev 0x108.
- pc=0x200, NEXT/INC4 with ready=0 for 2 cycles -> pc holds 0x200. Then ALU redirect alu=0x300 with ready=0 -> pc=0x300, pc_prev=0x200.
- pc=0x400, pc_prev=0x3FC, INC2P -> pc=0x3FE (IALIGN=16). Same stimulus with IALIGN=32 -> 0x400.
- IALIGN=32, JALR alu=0x1003 -> target 0x1002 faults: misalign_o=1, misalign_addr_o=0x1002, valid=0, pc unchanged. A NEXT write is ignored. TRAP trap_vec=0x8003 -> pc=0x8000, misalign_o=0, valid=1.
- MRET epc=0x2001 (IALIGN=16) -> pc=0x2000. pc=0xFFFF_FFFC with INC4 -> pc=0x0000_0000.
- Reserved sel=6 -> pc=RESET_VEC. Assert rst_n_i low while in HALT -> all outputs return to reset values asynchronously, before the next clock edge.
